// File: rtl/door_pkg.sv
// door_pkg
//   Shared definitions for the garage door input conditioner:
//   debouncer state encoding and the default debounce length.
package door_pkg;

  // Bit 1 of the encoding is the debounced level, so STABLE_HI/WAIT_LO read as 1.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b11,
    WAIT_LO   = 2'b10
  } deb_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/door_input_conditioner_if.sv
// door_input_conditioner_if
//   Groups the raw switch inputs and the conditioned outputs of the door
//   input conditioner.
//   Raw side  : Btn_Raw, Up_Lim_Raw, Dn_Lim_Raw (driven by the master)
//   Clean side: Activate, UP_Max, DN_Max, Limit_Fault (driven by the slave)
interface door_input_conditioner_if;

  logic Btn_Raw;
  logic Up_Lim_Raw;
  logic Dn_Lim_Raw;
  logic Activate;
  logic UP_Max;
  logic DN_Max;
  logic Limit_Fault;

  modport master (
    output Btn_Raw, Up_Lim_Raw, Dn_Lim_Raw,
    input  Activate, UP_Max, DN_Max, Limit_Fault
  );

  modport slave (
    input  Btn_Raw, Up_Lim_Raw, Dn_Lim_Raw,
    output Activate, UP_Max, DN_Max, Limit_Fault
  );

endinterface

// File: rtl/input_debouncer.sv
// input_debouncer
//   Two-flop synchroniser followed by a debounce FSM with a hold counter.
//   The output follows the synchronised input only after it has held a new
//   value for DEBOUNCE_CYCLES consecutive cycles.
//   Ports:
//     CLK   - system clock, rising edge
//     RST   - asynchronous active-low reset
//     Raw   - asynchronous raw input
//     Level - registered debounced level
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   STABLE_LO | output low, input agrees
//   WAIT_HI   | output low, input high, counting toward a rise
//   STABLE_HI | output high, input agrees
//   WAIT_LO   | output high, input low, counting toward a fall
module input_debouncer
  import door_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic CLK,
  input  logic RST,
  input  logic Raw,
  output logic Level
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  deb_state_t       state_q;
  deb_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= Raw;
      sync_2 <= sync_1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      Level   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Level decodes the current state, adding one register stage.
      Level   <= (state_q == STABLE_HI) || (state_q == WAIT_LO);
    end
  end

  // The counter only runs in the WAIT states and is capped at CNT_LAST.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      STABLE_LO: begin
        if (sync_2) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!sync_2) begin
          state_d = STABLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sync_2) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (sync_2) begin
          state_d = STABLE_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = STABLE_LO;
    endcase
  end

endmodule

// File: rtl/door_input_conditioner.sv
// door_input_conditioner
//   Front end for the garage door controller. Debounces the push-button and
//   both limit switches, turns a button press into a one-cycle Activate
//   pulse, and flags (and blocks activation during) the both-limits fault.
//   Ports:
//     CLK - system clock, rising edge
//     RST - asynchronous active-low reset
//     dif - slave side of door_input_conditioner_if:
//           Btn_Raw, Up_Lim_Raw, Dn_Lim_Raw in;
//           Activate, UP_Max, DN_Max, Limit_Fault out
module door_input_conditioner
  import door_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                      CLK,
  input  logic                      RST,
  door_input_conditioner_if.slave   dif
);

  logic btn_level;
  logic btn_level_q;
  logic up_level;
  logic dn_level;
  logic act_q;
  logic fault_q;
  logic both_limits;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_btn (
    .CLK   (CLK),
    .RST   (RST),
    .Raw   (dif.Btn_Raw),
    .Level (btn_level)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_up (
    .CLK   (CLK),
    .RST   (RST),
    .Raw   (dif.Up_Lim_Raw),
    .Level (up_level)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_dn (
    .CLK   (CLK),
    .RST   (RST),
    .Raw   (dif.Dn_Lim_Raw),
    .Level (dn_level)
  );

  assign both_limits = up_level & dn_level;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      btn_level_q <= 1'b0;
      act_q       <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      btn_level_q <= btn_level;
      act_q       <= btn_level & ~btn_level_q;
      fault_q     <= both_limits;
    end
  end

  // Gating on both the registered fault and the live limit pair covers the
  // first fault cycle too; a suppressed pulse is simply lost.
  assign dif.Activate    = act_q & ~fault_q & ~both_limits;
  assign dif.UP_Max      = up_level;
  assign dif.DN_Max      = dn_level;
  assign dif.Limit_Fault = fault_q;

endmodule

// File: tb/tb_door_input_conditioner.sv
// tb_door_input_conditioner
//   Self-checking bench for door_input_conditioner with DEBOUNCE_CYCLES = 4.
module tb_door_input_conditioner;

  localparam int D = 4;

  logic CLK;
  logic RST;
  int   vectors;
  int   miscompares;

  door_input_conditioner_if dif ();

  door_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK (CLK),
    .RST (RST),
    .dif (dif)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model. rh[k] is the raw sample taken k edges ago; the debouncer
  // sees raw values two edges late. A channel's debounced value flips once
  // the last D samples it has seen all disagree with it. dh[k] is the
  // debounced value k edges ago; outputs are read from that history with the
  // documented latencies.
  logic [2:0] rh [0:D+1];
  logic [2:0] dh [0:3];

  always @(posedge CLK or negedge RST) begin : ref_model
    logic [2:0] nrh [0:D+1];
    logic [2:0] ndeb;
    logic       all_diff;
    if (!RST) begin
      for (int k = 0; k <= D + 1; k++) rh[k] <= '0;
      for (int k = 0; k < 4; k++) dh[k] <= '0;
    end else begin
      nrh[0] = {dif.Dn_Lim_Raw, dif.Up_Lim_Raw, dif.Btn_Raw};
      for (int k = 1; k <= D + 1; k++) nrh[k] = rh[k-1];
      ndeb = dh[0];
      for (int c = 0; c < 3; c++) begin
        all_diff = 1'b1;
        for (int k = 2; k <= D + 1; k++)
          if (nrh[k][c] == dh[0][c]) all_diff = 1'b0;
        if (all_diff) ndeb[c] = ~dh[0][c];
      end
      for (int k = 0; k <= D + 1; k++) rh[k] <= nrh[k];
      dh[0] <= ndeb;
      for (int k = 1; k < 4; k++) dh[k] <= dh[k-1];
    end
  end

  logic       e_up, e_dn, e_fault, e_act;
  logic [3:0] exp_out;
  logic [3:0] got;

  assign e_up    = dh[1][1];
  assign e_dn    = dh[1][2];
  assign e_fault = dh[2][1] & dh[2][2];
  assign e_act   = dh[2][0] & ~dh[3][0] & ~e_fault & ~(e_up & e_dn);
  assign exp_out = {e_act, e_up, e_dn, e_fault};
  assign got     = {dif.Activate, dif.UP_Max, dif.DN_Max, dif.Limit_Fault};

  task automatic test_reset;
    RST = 1'b0;
    @(negedge CLK);
    vectors++;
    if (got !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_values got %b want 0000", got);
    end
    dif.Btn_Raw = 1'b1; dif.Up_Lim_Raw = 1'b1; dif.Dn_Lim_Raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      vectors++;
      if (got !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_hold i=%0d got %b want 0000", i, got);
      end
    end
    dif.Btn_Raw = 1'b0; dif.Up_Lim_Raw = 1'b0; dif.Dn_Lim_Raw = 1'b0;
    @(negedge CLK);
    #2 RST = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge CLK);
  endtask

  task automatic test_clean_press;
    int pulses = 0;
    int pulse_at = -1;
    for (int i = 0; i < 40; i++) begin
      dif.Btn_Raw = (i < 20);
      @(negedge CLK);
      vectors++;
      if (got !== exp_out) begin
        miscompares++;
        $display("FAIL clean_press i=%0d got %b want %b", i, got, exp_out);
      end
      if (dif.Activate) begin
        pulses++;
        pulse_at = i;
      end
    end
    vectors++;
    if (pulses !== 1 || pulse_at !== 7) begin
      miscompares++;
      $display("FAIL clean_press_pulse count=%0d after_edge=%0d want count=1 after_edge=7",
               pulses, pulse_at);
    end
  endtask

  task automatic test_bounce;
    bit [0:5] pat;
    int pulses = 0;
    int pulse_at = -1;
    pat = 6'b101101;
    for (int i = 0; i < 40; i++) begin
      dif.Btn_Raw = (i < 6) ? pat[i] : (i < 28);
      @(negedge CLK);
      vectors++;
      if (got !== exp_out) begin
        miscompares++;
        $display("FAIL bounce i=%0d got %b want %b", i, got, exp_out);
      end
      if (dif.Activate) begin
        pulses++;
        pulse_at = i;
      end
    end
    vectors++;
    if (pulses !== 1 || pulse_at !== 12) begin
      miscompares++;
      $display("FAIL bounce_pulse count=%0d after_edge=%0d want count=1 after_edge=12",
               pulses, pulse_at);
    end
  endtask

  task automatic test_glitch;
    int highs = 0;
    for (int i = 0; i < 20; i++) begin
      dif.Up_Lim_Raw = (i < 3);
      @(negedge CLK);
      vectors++;
      if (got !== exp_out) begin
        miscompares++;
        $display("FAIL glitch i=%0d got %b want %b", i, got, exp_out);
      end
      if (dif.UP_Max) highs++;
    end
    vectors++;
    if (highs !== 0) begin
      miscompares++;
      $display("FAIL glitch_up_max high_cycles=%0d want 0", highs);
    end
  endtask

  task automatic test_fault;
    int pulses = 0;
    int fault_rise = -1;
    int dn_fall = -1;
    int fault_fall = -1;
    for (int i = 0; i < 60; i++) begin
      dif.Up_Lim_Raw = (i < 50);
      dif.Dn_Lim_Raw = (i < 35);
      dif.Btn_Raw    = (i >= 15 && i < 30);
      @(negedge CLK);
      vectors++;
      if (got !== exp_out) begin
        miscompares++;
        $display("FAIL fault i=%0d got %b want %b", i, got, exp_out);
      end
      if (dif.Activate) pulses++;
      if (dif.Limit_Fault && fault_rise < 0) fault_rise = i;
      if (i >= 35 && !dif.DN_Max && dn_fall < 0) dn_fall = i;
      if (i >= 35 && !dif.Limit_Fault && fault_fall < 0) fault_fall = i;
    end
    vectors++;
    if (fault_rise !== 7) begin
      miscompares++;
      $display("FAIL fault_rise after_edge=%0d want 7", fault_rise);
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL fault_suppress pulses=%0d want 0", pulses);
    end
    vectors++;
    if (dn_fall !== 41 || fault_fall !== 42) begin
      miscompares++;
      $display("FAIL fault_clear dn_fall=%0d fault_fall=%0d want 41 42", dn_fall, fault_fall);
    end
  endtask

  task automatic test_mid_reset;
    int first_hi = -1;
    dif.Up_Lim_Raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      vectors++;
      if (got !== exp_out) begin
        miscompares++;
        $display("FAIL mid_reset_pre i=%0d got %b want %b", i, got, exp_out);
      end
    end
    #2 RST = 1'b0;
    #1;
    vectors++;
    if (got !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_async_clear got %b want 0000", got);
    end
    dif.Up_Lim_Raw = 1'b0;
    @(negedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
    dif.Dn_Lim_Raw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      vectors++;
      if (got !== exp_out) begin
        miscompares++;
        $display("FAIL mid_reset_dn i=%0d got %b want %b", i, got, exp_out);
      end
    end
    #2 RST = 1'b0;
    #1;
    vectors++;
    if (dif.DN_Max !== 1'b0 || got !== exp_out) begin
      miscompares++;
      $display("FAIL mid_reset_dn_clear got %b want %b", got, exp_out);
    end
    @(negedge CLK);
    #2 RST = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge CLK);
      vectors++;
      if (got !== exp_out) begin
        miscompares++;
        $display("FAIL mid_reset_post j=%0d got %b want %b", j, got, exp_out);
      end
      if (dif.DN_Max && first_hi < 0) first_hi = j;
    end
    vectors++;
    if (first_hi !== 6) begin
      miscompares++;
      $display("FAIL mid_reset_dn_rise after_edge=%0d want 6", first_hi);
    end
    dif.Dn_Lim_Raw = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge CLK);
  endtask

  task automatic test_independent;
    int dn_fall = -1;
    int act_at = -1;
    dif.Dn_Lim_Raw = 1'b1;
    for (int i = 0; i < 12; i++) @(negedge CLK);
    for (int i = 0; i < 20; i++) begin
      dif.Dn_Lim_Raw = 1'b0;
      dif.Btn_Raw    = 1'b1;
      @(negedge CLK);
      vectors++;
      if (got !== exp_out) begin
        miscompares++;
        $display("FAIL independent i=%0d got %b want %b", i, got, exp_out);
      end
      if (!dif.DN_Max && dn_fall < 0) dn_fall = i;
      if (dif.Activate && act_at < 0) act_at = i;
    end
    vectors++;
    if (dn_fall !== 6 || act_at !== 7) begin
      miscompares++;
      $display("FAIL independent_timing dn_fall=%0d act=%0d want 6 7", dn_fall, act_at);
    end
    dif.Btn_Raw = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge CLK);
  endtask

  task automatic test_random;
    int         rem [3];
    logic [2:0] val;
    val = '0;
    for (int c = 0; c < 3; c++) rem[c] = 0;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (rem[c] == 0) begin
          val[c] = ~val[c];
          rem[c] = int'($urandom_range(1, 9));
        end else begin
          rem[c]--;
        end
      end
      dif.Btn_Raw    = val[0];
      dif.Up_Lim_Raw = val[1];
      dif.Dn_Lim_Raw = val[2];
      if (i == 300) begin
        #2 RST = 1'b0;
        #2 RST = 1'b1;
      end
      @(negedge CLK);
      vectors++;
      if (got !== exp_out) begin
        miscompares++;
        $display("FAIL random i=%0d in=%b got %b want %b", i, val, got, exp_out);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST         = 1'b0;
    dif.Btn_Raw    = 1'b0;
    dif.Up_Lim_Raw = 1'b0;
    dif.Dn_Lim_Raw = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_fault();
    test_mid_reset();
    test_independent();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/door_input_conditioner.md
# door_input_conditioner

Front end for the garage door controller. It synchronises and debounces the raw push-button and the two limit switches, then delivers three clean signals to the downstream controller:

- a single-cycle `Activate` pulse,
- stable `UP_Max` / `DN_Max` levels.

It also flags the physically impossible case where both limits are asserted, and suppresses activation while that fault is present.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive synchronised cycles an input must hold a new value before the debounced output follows. Legal range 2..65535.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width. Derived; never overridden.

Ports:
- `CLK`: input, 1 bit, system clock. All state is on the rising edge.
- `RST`: input, 1 bit. Asynchronous, active-low reset.
- `Btn_Raw`: input, 1 bit. Raw activate push-button, asynchronous, bouncing, active-high.
- `Up_Lim_Raw`: input, 1 bit. Raw fully-open limit switch, asynchronous, active-high.
- `Dn_Lim_Raw`: input, 1 bit. Raw fully-closed limit switch, asynchronous, active-high.
- `Activate`: output, 1 bit. One-cycle pulse per debounced button press.
- `UP_Max`: output, 1 bit. Debounced upper limit level.
- `DN_Max`: output, 1 bit. Debounced lower limit level.
- `Limit_Fault`: output, 1 bit. High while both debounced limits are high.

## Operation

- **Synchroniser:** each raw input passes through a 2-flop synchroniser, reset to 0.
- **Debouncer:** each synchronised input drives an independent debouncer FSM.
  - States: `STABLE_LO`, `WAIT_HI`, `STABLE_HI`, `WAIT_LO`. Reset state is `STABLE_LO`, counter 0.
  - `STABLE_LO`: sync=1 → `WAIT_HI`, counter=1. Otherwise stay, counter=0.
  - `WAIT_HI`: sync=0 → `STABLE_LO`, counter=0 (glitch rejected). sync=1 and counter==`DEBOUNCE_CYCLES-1` → `STABLE_HI`. Otherwise counter+1.
  - `STABLE_HI` / `WAIT_LO`: mirror images of the above.
  - Debounced level is 1 in `STABLE_HI` and `WAIT_LO`, 0 otherwise. It is registered as a state decode.
  - The counter never exceeds `DEBOUNCE_CYCLES-1`, so no wrap can occur.
- **Activate pulse:**
  - A registered edge detector on the debounced button produces `Activate`=1 for exactly one cycle on the 0→1 transition.
  - Holding the button produces no further pulses.
  - Releasing the button produces no pulse.
- **Limit outputs:** `UP_Max` and `DN_Max` are the debounced limit levels, passed through unchanged.
- **Fault handling:**
  - `Limit_Fault` is registered: `UP_Max & DN_Max` from the previous cycle.
  - While `Limit_Fault`=1 or `UP_Max & DN_Max`=1, any `Activate` pulse is forced to 0. A press that debounces during a fault is discarded, not deferred.
- **Simultaneous events:** all three channels are fully independent. Simultaneous changes on them are processed in parallel with no priority.
- **Reset mid-operation:** `RST` low at any time immediately clears all synchronisers, FSMs, counters and outputs, independent of `CLK`. After release, an input that is already high is debounced afresh from `STABLE_LO`.

## Timing

- **Reset values:** `Activate`=0, `UP_Max`=0, `DN_Max`=0, `Limit_Fault`=0.
- **Reference point:** raw input rises before clock edge 0 and then stays stable.
  - The synchronised value is seen at edge 2.
  - The debounced level goes high after edge `DEBOUNCE_CYCLES+2`.
- **Latency to downstream signals:**
  - `UP_Max` / `DN_Max` follow the debounced level with D+2 edges of latency, where D = `DEBOUNCE_CYCLES`.
  - `Activate` is high for the single cycle after edge D+3.
  - `Limit_Fault` rises after edge D+3 of the later limit.
- **Falling transitions:** same latency as rising transitions.
- **Glitch rejection:** any synchronised pulse shorter than D cycles produces no change on any output.

## Structure

Shared package `door_pkg`:
- debouncer state encoding: `STABLE_LO`=2'b00, `WAIT_HI`=2'b01, `STABLE_HI`=2'b11, `WAIT_LO`=2'b10;
- the default `DEBOUNCE_CYCLES` constant.

One sub-module, `input_debouncer`:
- contains the synchroniser, FSM and counter;
- parameterised by `DEBOUNCE_CYCLES`;
- ports `CLK`, `RST`, `Raw`, `Level`;
- instantiated three times.

The top level holds:
- the button edge detector,
- the fault register,
- the suppression gating.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4.

1. **Clean press:** `Btn_Raw` 0→1, held 20 cycles → `Activate` high for exactly 1 cycle, after edge 7. No further pulses while held, and none on release.
2. **Bounce:** `Btn_Raw` toggles 1,0,1,1,0,1 (one value per cycle), then held at 1 → single `Activate` pulse, 7 edges after the final 0→1 transition.
3. **Short glitch:** `Up_Lim_Raw` high for 3 cycles, then low → `UP_Max` stays 0 throughout.
4. **Fault:**
   - `Up_Lim_Raw` and `Dn_Lim_Raw` both held high → `Limit_Fault`=1 after edge 7.
   - A button press during the fault → `Activate` stays 0.
   - Drop `Dn_Lim_Raw` → `Limit_Fault` returns to 0 one edge after `DN_Max` falls.
5. **Reset mid-debounce:** `Dn_Lim_Raw` high, `RST` pulsed low at cycle 4 → `DN_Max`=0 immediately. `DN_Max` goes high 6 edges after `RST` deasserts.
6. **Independent channels:** `Dn_Lim_Raw` falls and `Btn_Raw` rises in the same cycle → `DN_Max`=0 after edge 6 and `Activate` pulses after edge 7. No interaction between channels.
